serial_accumulator: RTL and testbench



---
 rtl/serial_accumulator.sv | 138 +++++++++++++
 tb/tb_serial_accumulator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_accumulator.sv
// Bit-serial window accumulator.
// Each accepted sample is added into the accumulator one bit per clock, LSB
// first, through a single one-bit full adder. A registered carry closes the
// loop. After TAPS samples the window sum is offered on a valid/ready output.

// One-bit full adder cell used by the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_accumulator #(
  parameter int WIDTH = 8,
  parameter int TAPS  = 3,
  parameter int ACC_W = 10
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       In_Valid,
  output logic                       In_Ready,
  input  logic [WIDTH-1:0]           In_Data,
  output logic                       Out_Valid,
  input  logic                       Out_Ready,
  output logic [ACC_W-1:0]           Out_Sum,
  output logic                       Busy,
  output logic [$clog2(TAPS+1)-1:0]  Tap_Count
);

  localparam int TC_W = $clog2(TAPS + 1);
  localparam int BC_W = $clog2(ACC_W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;

  // Parameter sanity: the accumulator must hold TAPS full-scale samples.
  generate
    if (TAPS < 2 || TAPS > 16) begin : g_bad_taps
      $error("serial_accumulator: TAPS must be in 2..16");
    end
    if (ACC_W < WIDTH + $clog2(TAPS)) begin : g_bad_acc_w
      $error("serial_accumulator: ACC_W too small for WIDTH and TAPS");
    end
  endgenerate

  logic [1:0]       state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] op_reg;
  logic             carry_reg;
  logic [BC_W-1:0]  bit_cnt_reg;
  logic [TC_W-1:0]  tap_cnt_reg;
  logic [ACC_W-1:0] sum_reg;

  logic             fa_s;
  logic             fa_cout;
  logic [ACC_W-1:0] acc_next;
  logic [TC_W-1:0]  tap_cnt_next;
  logic             last_bit;

  // The single adder cell: accumulator LSB + operand LSB + stored carry.
  full_adder u_fa (
    .a    (acc_reg[0]),
    .b    (op_reg[0]),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Sum bit enters at the top so that after ACC_W shifts the word is aligned.
  always_comb begin
    acc_next     = {fa_s, acc_reg[ACC_W-1:1]};
    tap_cnt_next = tap_cnt_reg + 1'b1;
    last_bit     = (bit_cnt_reg == BC_W'(ACC_W - 1));
  end

  // Handshake and status outputs decode the registered state; only the
  // reset input gates In_Ready so it reads low during the reset cycle.
  assign In_Ready  = (state_reg == IDLE) && !RST;
  assign Out_Valid = (state_reg == EMIT);
  assign Busy      = (state_reg == ADD);
  assign Out_Sum   = sum_reg;
  assign Tap_Count = tap_cnt_reg;

  // Control FSM and serial datapath.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      op_reg      <= '0;
      carry_reg   <= 1'b0;
      bit_cnt_reg <= '0;
      tap_cnt_reg <= '0;
      sum_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (In_Valid && In_Ready) begin
            op_reg      <= ACC_W'(In_Data);
            bit_cnt_reg <= '0;
            carry_reg   <= 1'b0;
            state_reg   <= ADD;
          end
        end
        ADD: begin
          acc_reg     <= acc_next;
          op_reg      <= op_reg >> 1;
          carry_reg   <= fa_cout;
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
          if (last_bit) begin
            // Final carry out is dropped: the sum wraps modulo 2^ACC_W.
            tap_cnt_reg <= tap_cnt_next;
            if (tap_cnt_next == TC_W'(TAPS)) begin
              sum_reg   <= acc_next;
              state_reg <= EMIT;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        EMIT: begin
          if (Out_Ready) begin
            acc_reg     <= '0;
            tap_cnt_reg <= '0;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_accumulator.sv
// Directed bench for serial_accumulator with default parameters
// (WIDTH=8, TAPS=3, ACC_W=10).
module tb_serial_accumulator;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_sum;
  logic       busy;
  logic [1:0] tap_count;

  int tests;
  int fails;
  int hs_count;
  int hs_start;

  serial_accumulator #(.WIDTH(8), .TAPS(3), .ACC_W(10)) dut (
    .CLK       (clk),
    .RST       (rst),
    .In_Valid  (in_valid),
    .In_Ready  (in_ready),
    .In_Data   (in_data),
    .Out_Valid (out_valid),
    .Out_Ready (out_ready),
    .Out_Sum   (out_sum),
    .Busy      (busy),
    .Tap_Count (tap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output handshake counter.
  always @(posedge clk) begin
    if (out_valid && out_ready) hs_count <= hs_count + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one sample when the block is ready; returns just after the accept edge.
  task automatic send(input logic [7:0] value);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) begin
      check("send_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_valid = 1'b1;
      in_data  = value;
      step();
      in_valid = 1'b0;
      in_data  = 8'hxx;
      $display("[TB] t=%0t sample %0d accepted", $time, value);
    end
  endtask

  // Wait for Out_Valid and compare the window sum.
  task automatic wait_sum(input string tag, input logic [9:0] exp);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check(tag, 32'(out_sum), 32'(exp));
    $display("[TB] t=%0t window sum %0d presented", $time, out_sum);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    hs_count  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b1;

    // Reset state
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_tap_count", 32'(tap_count), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Window 10+20+30
    send(8'd10);
    send(8'd20);
    while (!in_ready) step();
    check("w1_tap2", 32'(tap_count), 32'd2);
    send(8'd30);
    wait_sum("w1_sum", 10'd60);
    step();
    check("w1_valid_drop", 32'(out_valid), 32'd0);
    check("w1_tap_clear", 32'(tap_count), 32'd0);
    check("w1_sum_hold", 32'(out_sum), 32'd60);

    // Full-scale samples exercise carry across all bits
    send(8'd255);
    send(8'd255);
    send(8'd255);
    wait_sum("w2_sum", 10'd765);
    step();

    // Busy / ready timing for one sample
    while (!in_ready) step();
    send(8'd7);
    for (int i = 0; i < 10; i++) begin
      check("lat_ready_low", 32'(in_ready), 32'd0);
      check("lat_busy_high", 32'(busy), 32'd1);
      step();
    end
    check("lat_ready_back", 32'(in_ready), 32'd1);
    check("lat_busy_low", 32'(busy), 32'd0);
    check("lat_tap1", 32'(tap_count), 32'd1);

    // Back-pressure on the output; 99 must not be taken
    send(8'd8);
    out_ready = 1'b0;
    send(8'd9);
    wait_sum("bp_sum", 10'd24);
    in_valid = 1'b1;
    in_data  = 8'd99;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_sum_hold", 32'(out_sum), 32'd24);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    check("bp_no_accept_tap", 32'(tap_count), 32'd0);
    check("bp_no_accept_busy", 32'(busy), 32'd0);

    // Reset during ADD discards the partial window
    send(8'd100);
    send(8'd50);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tap", 32'(tap_count), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_sum", 32'(out_sum), 32'd0);
    rst = 1'b0;
    send(8'd1);
    send(8'd2);
    send(8'd3);
    wait_sum("after_rst_sum", 10'd6);
    step();

    // Two back-to-back windows
    hs_start = hs_count;
    send(8'd1);
    send(8'd2);
    send(8'd3);
    wait_sum("b2b_sum1", 10'd6);
    send(8'd4);
    send(8'd5);
    send(8'd6);
    wait_sum("b2b_sum2", 10'd15);
    step();
    step();
    check("b2b_handshakes", 32'(hs_count - hs_start), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global guard so a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
